// File: rtl/exit_distrib.sv
`default_nettype none
// ============================================================================
// Module   : exit_distrib
// Purpose  : Egress packet distributor. Takes the serial word stream from the
//            shared buffer and steers whole packets into one of four egress
//            FIFOs, chosen by the header word. The port is held until the
//            last payload word has been accepted.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            i_sdata/i_data_valid  - incoming stream word and its valid
//            o_ready               - word accepted when valid & ready
//            i_fifoN_full (N=1..4) - almost-full of egress FIFO N
//            o_fifoN_wr_en         - registered write strobe to FIFO N
//            o_wdata               - registered shared write data
//            o_pkt_cnt_pN          - completed-packet counters (optional)
// Config   : EXIT_PKT_CNT_EN - adds four CNT_W-bit completed-packet counters
// Revision : 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module exit_distrib #(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int LEN_W      = 8
`ifdef EXIT_PKT_CNT_EN
   ,
   parameter int CNT_W      = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] i_sdata,
   input  logic                  i_data_valid,
   output logic                  o_ready,
   input  logic                  i_fifo1_full,
   input  logic                  i_fifo2_full,
   input  logic                  i_fifo3_full,
   input  logic                  i_fifo4_full,
   output logic                  o_fifo1_wr_en,
   output logic                  o_fifo2_wr_en,
   output logic                  o_fifo3_wr_en,
   output logic                  o_fifo4_wr_en,
   output logic [DATA_WIDTH-1:0] o_wdata
`ifdef EXIT_PKT_CNT_EN
   ,
   output logic [CNT_W-1:0]      o_pkt_cnt_p1,
   output logic [CNT_W-1:0]      o_pkt_cnt_p2,
   output logic [CNT_W-1:0]      o_pkt_cnt_p3,
   output logic [CNT_W-1:0]      o_pkt_cnt_p4
`endif
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BODY = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [LEN_W-1:0]        remain_q, remain_d;
   logic [1:0]              dest_q, dest_d;
   logic [3:0]              wr_en_q;
   logic [DATA_WIDTH-1:0]   wdata_q;

   logic [1:0]              w_hdr_dest;
   logic [LEN_W-1:0]        w_hdr_len;
   logic [1:0]              w_sel_dest;
   logic [3:0]              w_full_vec;
   logic [3:0]              w_sel_onehot;
   logic                    w_accept;
   logic                    w_last;

   // Header fields are decoded straight off the stream so a header can be
   // accepted in the same cycle it is presented.
   assign w_hdr_dest = i_sdata[1:0];
   assign w_hdr_len  = i_sdata[8+LEN_W-1:8];

   assign w_full_vec = {i_fifo4_full, i_fifo3_full, i_fifo2_full, i_fifo1_full};

   // In IDLE the destination comes from the word on the bus; in BODY from
   // the latched header.
   assign w_sel_dest   = (state_q == S_IDLE) ? w_hdr_dest : dest_q;
   assign w_sel_onehot = 4'b0001 << w_sel_dest;

   // Almost-full leaves one spare entry, which absorbs the registered write
   // of the word accepted in the same cycle the flag rises.
   assign o_ready  = rst_n & ~w_full_vec[w_sel_dest];
   assign w_accept = i_data_valid & o_ready;

   // Last word of a packet: a zero-length header, or the final payload word.
   assign w_last = (state_q == S_IDLE) ? (w_hdr_len == '0)
                                       : (remain_q == LEN_W'(1));

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      dest_d   = dest_q;
      if (w_accept) begin
         case (state_q)
            S_IDLE: begin
               if (w_hdr_len != '0) begin
                  state_d  = S_BODY;
                  remain_d = w_hdr_len;
                  dest_d   = w_hdr_dest;
               end
            end
            S_BODY: begin
               remain_d = remain_q - LEN_W'(1);
               if (remain_q == LEN_W'(1)) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         remain_q <= '0;
         dest_q   <= '0;
         wr_en_q  <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         dest_q   <= dest_d;
         wr_en_q  <= w_accept ? w_sel_onehot : 4'b0000;
         if (w_accept) begin
            wdata_q <= i_sdata;
         end
      end
   end

   assign o_fifo1_wr_en = wr_en_q[0];
   assign o_fifo2_wr_en = wr_en_q[1];
   assign o_fifo3_wr_en = wr_en_q[2];
   assign o_fifo4_wr_en = wr_en_q[3];
   assign o_wdata       = wdata_q;

`ifdef EXIT_PKT_CNT_EN
   logic [CNT_W-1:0] cnt_q [4];

   // Counter update is registered together with the write strobe of the
   // packet's last word; natural binary overflow provides the wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (w_accept && w_last) begin
         cnt_q[w_sel_dest] <= cnt_q[w_sel_dest] + CNT_W'(1);
      end
   end

   assign o_pkt_cnt_p1 = cnt_q[0];
   assign o_pkt_cnt_p2 = cnt_q[1];
   assign o_pkt_cnt_p3 = cnt_q[2];
   assign o_pkt_cnt_p4 = cnt_q[3];
`else
   // Without the counters, packet completion has no observer.
   logic w_unused_last;
   assign w_unused_last = w_last;
`endif

endmodule

`default_nettype wire
